dht11_sample_scheduler: RTL and testbench

Controller that sequences the DHT11 reader. It drives the reader's enable and enforces the sensor's minimum inter-read gap. It issues periodic and on-demand samples, times out hung transactions and retries them, then latches the last checksum-valid humidity/temperature pair for downstream cold-storage logic. It sits between the reader and the control/display logic, clocked at 100 MHz.

---
 rtl/dht11_sample_scheduler_if.sv | 32 +++
 rtl/dht11_sample_scheduler.sv | 145 ++++++++++++++
 tb/tb_dht11_sample_scheduler.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dht11_sample_scheduler_if.sv
// Purpose: bundles the scheduler's request, reader-side and result signals into one port.
// Latency: none, this is wiring only.
// Backpressure: none. The reader answers through sensor_ready while sensor_en is high.
// Ports: master = scheduler side (drives sensor_en and the results); slave = reader plus control side.
interface dht11_sample_scheduler_if;
  logic       auto_en;
  logic       req;
  logic       sensor_en;
  logic       sensor_ready;
  logic [7:0] sensor_humidity;
  logic [7:0] sensor_temperature;
  logic [7:0] humidity;
  logic [7:0] temperature;
  logic       valid;
  logic       sample_strobe;
  logic       busy;
  logic       timeout_err;
  logic [3:0] retry_cnt;
  logic [7:0] fail_cnt;

  modport master (
    input  auto_en, req, sensor_ready, sensor_humidity, sensor_temperature,
    output sensor_en, humidity, temperature, valid, sample_strobe, busy,
           timeout_err, retry_cnt, fail_cnt
  );

  modport slave (
    output auto_en, req, sensor_ready, sensor_humidity, sensor_temperature,
    input  sensor_en, humidity, temperature, valid, sample_strobe, busy,
           timeout_err, retry_cnt, fail_cnt
  );
endinterface

// File: rtl/dht11_sample_scheduler.sv
// Purpose: sequences DHT11 reads (periodic/on-demand, min gap, timeout+retry) and holds the last valid sample.
// Latency: a read starts MIN_GAP_CYCLES+1 cycles after the previous one ends; results appear one cycle after sensor_ready.
// Backpressure: extra requests coalesce into a single pending flag and never abort an in-flight attempt.
// Ports: clk and rst_n (sync, active-low), plus bus (dht11_sample_scheduler_if.master). All outputs are registered.
module dht11_sample_scheduler #(
  parameter int unsigned PERIOD_CYCLES  = 500000000,
  parameter int unsigned MIN_GAP_CYCLES = 200000000,
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 32
) (
  input logic                      clk,
  input logic                      rst_n,
  dht11_sample_scheduler_if.master bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GAP    = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_FULL    = CNT_W'(MIN_GAP_CYCLES);
  localparam logic [CNT_W-1:0] ACT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  logic [1:0]       state;
  logic             pending;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] act_cnt;
  logic             sensor_en;
  logic [7:0]       humidity;
  logic [7:0]       temperature;
  logic             valid;
  logic             sample_strobe;
  logic             busy;
  logic             timeout_err;
  logic [3:0]       retry_cnt;
  logic [7:0]       fail_cnt;
  logic             period_tick;

  assign period_tick = bus.auto_en && (period_cnt == PERIOD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pending       <= 1'b0;
      period_cnt    <= '0;
      gap_cnt       <= '0;
      act_cnt       <= '0;
      sensor_en     <= 1'b0;
      humidity      <= 8'd0;
      temperature   <= 8'd0;
      valid         <= 1'b0;
      sample_strobe <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      retry_cnt     <= 4'd0;
      fail_cnt      <= 8'd0;
    end else begin
      sample_strobe <= 1'b0;

      if (!bus.auto_en || period_tick) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + CNT_ONE;
      end

      // Idle time is counted in IDLE and GAP alike, so a request arriving
      // after a long quiet spell goes straight through GAP.
      if (state != ACTIVE && gap_cnt != GAP_FULL) begin
        gap_cnt <= gap_cnt + CNT_ONE;
      end

      case (state)
        IDLE: begin
          if (pending) begin
            state     <= GAP;
            busy      <= 1'b1;
            retry_cnt <= 4'd0;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_FULL) begin
            state     <= ACTIVE;
            sensor_en <= 1'b1;
            act_cnt   <= '0;
            pending   <= 1'b0;
          end
        end
        ACTIVE: begin
          act_cnt <= act_cnt + CNT_ONE;
          // A result that lands on the final timeout cycle still counts.
          if (bus.sensor_ready) begin
            humidity      <= bus.sensor_humidity;
            temperature   <= bus.sensor_temperature;
            valid         <= 1'b1;
            sample_strobe <= 1'b1;
            timeout_err   <= 1'b0;
            retry_cnt     <= 4'd0;
            sensor_en     <= 1'b0;
            gap_cnt       <= '0;
            state         <= IDLE;
            busy          <= 1'b0;
          end else if (act_cnt == ACT_LAST) begin
            sensor_en <= 1'b0;
            gap_cnt   <= '0;
            if (retry_cnt < RETRY_MAX) begin
              retry_cnt <= retry_cnt + 4'd1;
              state     <= GAP;
            end else begin
              timeout_err <= 1'b1;
              if (fail_cnt != 8'hFF) begin
                fail_cnt <= fail_cnt + 8'd1;
              end
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          sensor_en <= 1'b0;
          busy      <= 1'b0;
        end
      endcase

      // This comes after the case so that a request on the launch edge
      // is kept rather than lost.
      if (bus.req || period_tick) begin
        pending <= 1'b1;
      end
    end
  end

  assign bus.sensor_en     = sensor_en;
  assign bus.humidity      = humidity;
  assign bus.temperature   = temperature;
  assign bus.valid         = valid;
  assign bus.sample_strobe = sample_strobe;
  assign bus.busy          = busy;
  assign bus.timeout_err   = timeout_err;
  assign bus.retry_cnt     = retry_cnt;
  assign bus.fail_cnt      = fail_cnt;
endmodule

// File: tb/tb_dht11_sample_scheduler.sv
// Purpose: directed self-checking bench for dht11_sample_scheduler with a responding sensor model.
// Latency: sensor model raises sensor_ready resp_dly cycles after sensor_en rises.
// Backpressure: not applicable; expected samples queue up in sb_q until sample_strobe appears.
module tb_dht11_sample_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dht11_sample_scheduler_if bus_if ();

  dht11_sample_scheduler #(
    .PERIOD_CYCLES (100),
    .MIN_GAP_CYCLES(20),
    .TIMEOUT_CYCLES(10),
    .MAX_RETRIES   (2),
    .CNT_W         (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  // Stimulus and sensor model state.
  logic       auto_en   = 1'b0;
  logic       req       = 1'b0;
  logic       stray_rdy = 1'b0;
  logic       model_rdy = 1'b0;
  logic       resp_en   = 1'b0;
  int         resp_dly  = 5;
  logic [7:0] resp_hum  = 8'h00;
  logic [7:0] resp_tmp  = 8'h00;
  int         hi_cnt    = 0;

  assign bus_if.auto_en            = auto_en;
  assign bus_if.req                = req;
  assign bus_if.sensor_ready       = model_rdy | stray_rdy;
  assign bus_if.sensor_humidity    = stray_rdy ? 8'hAA : resp_hum;
  assign bus_if.sensor_temperature = stray_rdy ? 8'h55 : resp_tmp;

  // Scoreboard of expected {humidity, temperature} and event logs.
  logic [15:0] sb_q[$];
  int          rise_q[$];
  int          fall_q[$];
  int          cyc = 0;
  int          strobe_cnt = 0;
  logic        en_d = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Sensor model: answers resp_dly cycles after sensor_en rises and
  // records the sample the DUT must later publish.
  always @(negedge clk) begin
    if (bus_if.sensor_en === 1'b1) begin
      hi_cnt = hi_cnt + 1;
      if (resp_en && hi_cnt == resp_dly) begin
        model_rdy = 1'b1;
        sb_q.push_back({resp_hum, resp_tmp});
      end else begin
        model_rdy = 1'b0;
      end
    end else begin
      hi_cnt    = 0;
      model_rdy = 1'b0;
    end
  end

  // Monitor: logs sensor_en edges and checks every latched sample.
  always @(negedge clk) begin
    logic [15:0] exp_s;
    cyc++;
    if (bus_if.sensor_en === 1'b1 && en_d === 1'b0) rise_q.push_back(cyc);
    if (bus_if.sensor_en === 1'b0 && en_d === 1'b1) fall_q.push_back(cyc);
    en_d = bus_if.sensor_en;
    if (bus_if.sample_strobe === 1'b1) begin
      strobe_cnt++;
      if (sb_q.size() == 0) begin
        check("sb_unexpected_strobe", 32'd1, 32'd0);
      end else begin
        exp_s = sb_q.pop_front();
        check("sb_humidity", {24'd0, bus_if.humidity}, {24'd0, exp_s[15:8]});
        check("sb_temperature", {24'd0, bus_if.temperature}, {24'd0, exp_s[7:0]});
      end
    end
  end

  task automatic pulse_req();
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
  endtask

  // Waits (bounded) for sensor_en high; an expired bound counts as a failure.
  task automatic wait_rise(input string tag);
    int n = 0;
    while (bus_if.sensor_en !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus_if.sensor_en}, 32'd1);
  endtask

  initial begin
    int k;
    int r0;
    int f0;
    int s0;
    int min_iv;
    logic seen;

    // Reset values.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sensor_en", {31'd0, bus_if.sensor_en}, 32'd0);
    check("rst_valid", {31'd0, bus_if.valid}, 32'd0);
    check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    check("rst_humidity", {24'd0, bus_if.humidity}, 32'd0);
    check("rst_fail_cnt", {24'd0, bus_if.fail_cnt}, 32'd0);
    check("rst_strobe", {31'd0, bus_if.sample_strobe}, 32'd0);

    // 1: first read. req lands at edge 2; gap_cnt reaches 20 at edge 20,
    // GAP sees it at edge 21 and raises sensor_en then.
    rst_n    = 1'b1;
    resp_en  = 1'b1;
    resp_dly = 5;
    resp_hum = 8'h37;
    resp_tmp = 8'h19;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      req = (k == 1);
      if (bus_if.sensor_en === 1'b1) seen = 1'b1;
    end
    req = 1'b0;
    check("t1_rise_cycle", k, 32'd21);
    check("t1_busy", {31'd0, bus_if.busy}, 32'd1);
    repeat (5) @(negedge clk);
    check("t1_en_dropped", {31'd0, bus_if.sensor_en}, 32'd0);
    check("t1_strobe_on", {31'd0, bus_if.sample_strobe}, 32'd1);
    @(negedge clk);
    check("t1_strobe_off", {31'd0, bus_if.sample_strobe}, 32'd0);
    check("t1_valid", {31'd0, bus_if.valid}, 32'd1);
    check("t1_humidity", {24'd0, bus_if.humidity}, 32'h37);
    check("t1_temperature", {24'd0, bus_if.temperature}, 32'h19);
    check("t1_busy_after", {31'd0, bus_if.busy}, 32'd0);

    // sensor_ready outside ACTIVE must be ignored.
    s0 = strobe_cnt;
    stray_rdy = 1'b1;
    repeat (2) @(negedge clk);
    stray_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_no_strobe", strobe_cnt - s0, 32'd0);
    check("stray_humidity", {24'd0, bus_if.humidity}, 32'h37);

    // 2: silent sensor -> three 10-cycle pulses, then failure.
    resp_en = 1'b0;
    r0 = rise_q.size();
    f0 = fall_q.size();
    pulse_req();
    repeat (120) @(negedge clk);
    check("t2_pulses", rise_q.size() - r0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (r0 + i < rise_q.size() && f0 + i < fall_q.size())
        check("t2_high_len", fall_q[f0 + i] - rise_q[r0 + i], 32'd10);
    end
    for (int i = 0; i < 2; i++) begin
      if (r0 + i + 1 < rise_q.size() && f0 + i < fall_q.size())
        check_range("t2_low_len", rise_q[r0 + i + 1] - fall_q[f0 + i], 20, 1000);
    end
    check("t2_timeout_err", {31'd0, bus_if.timeout_err}, 32'd1);
    check("t2_retry_cnt", {28'd0, bus_if.retry_cnt}, 32'd2);
    check("t2_fail_cnt", {24'd0, bus_if.fail_cnt}, 32'd1);
    check("t2_humidity_kept", {24'd0, bus_if.humidity}, 32'h37);
    check("t2_temperature_kept", {24'd0, bus_if.temperature}, 32'h19);
    check("t2_valid_kept", {31'd0, bus_if.valid}, 32'd1);

    // 3: periodic sampling for 1000 cycles.
    resp_en  = 1'b1;
    resp_dly = 5;
    resp_hum = 8'h40;
    resp_tmp = 8'h1A;
    s0 = strobe_cnt;
    r0 = rise_q.size();
    @(negedge clk) auto_en = 1'b1;
    repeat (1000) @(negedge clk);
    check_range("t3_strobes", strobe_cnt - s0, 9, 11);
    auto_en = 1'b0;
    repeat (150) @(negedge clk);
    min_iv = 100000;
    for (int i = r0; i + 1 < rise_q.size(); i++) begin
      if (rise_q[i + 1] - rise_q[i] < min_iv) min_iv = rise_q[i + 1] - rise_q[i];
    end
    check_range("t3_min_rise_gap", min_iv, 30, 100000);
    check("t3_timeout_cleared", {31'd0, bus_if.timeout_err}, 32'd0);
    check("t3_busy_idle", {31'd0, bus_if.busy}, 32'd0);

    // 4: three requests during ACTIVE coalesce into one follow-up read.
    resp_dly = 8;
    resp_hum = 8'h41;
    resp_tmp = 8'h1B;
    s0 = strobe_cnt;
    r0 = rise_q.size();
    f0 = fall_q.size();
    pulse_req();
    wait_rise("t4_first_rise");
    repeat (3) pulse_req();
    repeat (150) @(negedge clk);
    check("t4_reads", rise_q.size() - r0, 32'd2);
    check("t4_strobes", strobe_cnt - s0, 32'd2);
    if (r0 + 1 < rise_q.size() && f0 < fall_q.size())
      check_range("t4_followup_gap", rise_q[r0 + 1] - fall_q[f0], 20, 1000);

    // 5: sensor_ready on the last timeout cycle wins over the timeout.
    resp_dly = 10;
    resp_hum = 8'h42;
    resp_tmp = 8'h1C;
    s0 = strobe_cnt;
    r0 = rise_q.size();
    f0 = fall_q.size();
    pulse_req();
    repeat (100) @(negedge clk);
    check("t5_reads", rise_q.size() - r0, 32'd1);
    check("t5_strobes", strobe_cnt - s0, 32'd1);
    if (r0 < rise_q.size() && f0 < fall_q.size())
      check("t5_high_len", fall_q[f0] - rise_q[r0], 32'd10);
    check("t5_timeout_err", {31'd0, bus_if.timeout_err}, 32'd0);
    check("t5_retry_cnt", {28'd0, bus_if.retry_cnt}, 32'd0);
    check("t5_humidity", {24'd0, bus_if.humidity}, 32'h42);

    // 6: reset in the middle of ACTIVE.
    resp_en = 1'b0;
    pulse_req();
    wait_rise("t6_rise");
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_sensor_en", {31'd0, bus_if.sensor_en}, 32'd0);
    check("t6_valid", {31'd0, bus_if.valid}, 32'd0);
    check("t6_fail_cnt", {24'd0, bus_if.fail_cnt}, 32'd0);
    check("t6_humidity", {24'd0, bus_if.humidity}, 32'd0);
    check("t6_temperature", {24'd0, bus_if.temperature}, 32'd0);
    check("t6_busy", {31'd0, bus_if.busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
